// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: bundles the engine's register window (csb_i/wen_i/addr_i/data_i/data_o), its SRAM-style memory port (mem_*) and done_irq_o; master = SoC/memory side, slave = engine
interface dma_copy_engine_if #(parameter int ADDR_WIDTH = 11);
  logic                  csb_i;
  logic                  wen_i;
  logic [3:0]            addr_i;
  logic [31:0]           data_i;
  logic [31:0]           data_o;
  logic                  mem_csb_o;
  logic                  mem_web_o;
  logic [3:0]            mem_wmask_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_din_o;
  logic [31:0]           mem_dout_i;
  logic                  mem_gnt_i;
  logic                  done_irq_o;
  modport slave (
    input  csb_i, wen_i, addr_i, data_i, mem_dout_i, mem_gnt_i,
    output data_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o, done_irq_o
  );
  modport master (
    output csb_i, wen_i, addr_i, data_i, mem_dout_i, mem_gnt_i,
    input  data_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o, mem_din_o, done_irq_o
  );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular mem-to-mem copy engine; ports clk_i, reset_i (sync, active-high), bus (slave: SRC/DST/LEN/CTRL register window, SRAM-style initiator port, done_irq_o pulsed in FIN only when DMA_IRQ_EN is defined)
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 16
) (
  input logic clk_i,
  input logic reset_i,
  dma_copy_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, RDW, WR, FIN} state_t;
  state_t state, state_n;
  logic [31:0] src, dst, cur_src, cur_dst, buffer;
  logic [LEN_WIDTH-1:0] len, rem;
  logic done, err, wr, start, misal, busy;
  logic [1:0] sel;
  assign sel = bus.addr_i[3:2];
  assign wr = !bus.csb_i && !bus.wen_i;
  assign busy = state != IDLE;
  assign start = wr && sel == 2'd3 && bus.data_i[0] && !busy;
  assign misal = |src[1:0] || |dst[1:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? ((misal || len == '0) ? FIN : RD) : IDLE;
      RD: state_n = bus.mem_gnt_i ? RDW : RD;
      RDW: state_n = WR;
      WR: state_n = bus.mem_gnt_i ? (rem == LEN_WIDTH'(1) ? FIN : RD) : WR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      done <= 1'b0;
      err <= 1'b0;
      cur_src <= '0;
      cur_dst <= '0;
      rem <= '0;
      buffer <= '0;
    end else begin
      state <= state_n;
      if (wr && !busy && sel == 2'd0) src <= bus.data_i;
      if (wr && !busy && sel == 2'd1) dst <= bus.data_i;
      if (wr && !busy && sel == 2'd2) len <= bus.data_i[LEN_WIDTH-1:0];
      if (wr && sel == 2'd3 && bus.data_i[2]) done <= 1'b0;
      if (wr && sel == 2'd3 && bus.data_i[3]) err <= 1'b0;
      if (start) begin
        done <= 1'b0;
        err <= misal;
        cur_src <= src;
        cur_dst <= dst;
        rem <= len;
      end
      if (state == RDW) buffer <= bus.mem_dout_i;
      if (state == WR && bus.mem_gnt_i) begin
        cur_src <= cur_src + 32'd4;
        cur_dst <= cur_dst + 32'd4;
        rem <= rem - 1'b1;
      end
      if (state == FIN) done <= 1'b1;
    end
  end
  assign bus.mem_csb_o = !(state == RD || state == WR);
  assign bus.mem_web_o = state != WR;
  assign bus.mem_wmask_o = 4'hF;
  assign bus.mem_addr_o = state == WR ? cur_dst[ADDR_WIDTH+1:2] : state == RD ? cur_src[ADDR_WIDTH+1:2] : '0;
  assign bus.mem_din_o = state == WR ? buffer : '0;
  assign bus.data_o = bus.csb_i ? '0 : sel == 2'd0 ? src : sel == 2'd1 ? dst : sel == 2'd2 ? 32'(len) : {28'd0, err, done, busy, 1'b0};
`ifdef DMA_IRQ_EN
  assign bus.done_irq_o = state == FIN;
`else
  assign bus.done_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed self-checking bench for dma_copy_engine with a 1-cycle-latency SRAM model
module tb_dma_copy_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dma_copy_engine_if #(.ADDR_WIDTH(11)) bus();
  dma_copy_engine #(.ADDR_WIDTH(11), .LEN_WIDTH(16)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
`ifdef DMA_IRQ_EN
  localparam int IRQ_PER = 1;
`else
  localparam int IRQ_PER = 0;
`endif
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:2047];
  logic bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int csb_cycles = 0, acc_rd = 0, acc_wr = 0, irq_cnt = 0;
  logic [7:0] acc_log = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!bus.mem_csb_o && bus.mem_gnt_i) begin
      if (!bus.mem_web_o) mem[bus.mem_addr_o] <= bus.mem_din_o;
      else bus.mem_dout_i <= mem[bus.mem_addr_o];
    end
    if (!bus.mem_csb_o) csb_cycles <= csb_cycles + 1;
    if (!bus.mem_csb_o && bus.mem_gnt_i) begin
      acc_log <= {acc_log[6:0], bus.mem_web_o};
      if (bus.mem_web_o) acc_rd <= acc_rd + 1;
      else acc_wr <= acc_wr + 1;
    end
    if (bus.done_irq_o) irq_cnt <= irq_cnt + 1;
  end
  function automatic logic [31:0] pat(input int i);
    pat = 32'h1234_5678 ^ (32'(i) * 32'h0101_0103);
  endfunction
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus.csb_i = 1'b0; bus.wen_i = 1'b0; bus.addr_i = a; bus.data_i = d;
    @(negedge clk);
    bus.csb_i = 1'b1; bus.wen_i = 1'b1;
  endtask
  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus.csb_i = 1'b0; bus.wen_i = 1'b1; bus.addr_i = a;
    #1;
    d = bus.data_o;
    bus.csb_i = 1'b1;
  endtask
  task automatic load(input int a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a[10:0]; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask
  task automatic wait_done(inout int edges);
    logic [31:0] c;
    rd_reg(4'd12, c);
    while (!c[2] && edges < 200) begin
      @(negedge clk);
      edges++;
      rd_reg(4'd12, c);
    end
  endtask
  task automatic test_reset;
    logic [31:0] c;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.mem_csb_o !== 1'b1) begin failures++; $display("FAIL reset_csb got=%b exp=1", bus.mem_csb_o); end
    checks++; if (bus.mem_web_o !== 1'b1) begin failures++; $display("FAIL reset_web got=%b exp=1", bus.mem_web_o); end
    checks++; if (bus.mem_wmask_o !== 4'hF) begin failures++; $display("FAIL reset_wmask got=%h exp=f", bus.mem_wmask_o); end
    checks++; if (bus.mem_addr_o !== 11'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr_o); end
    checks++; if (bus.mem_din_o !== 32'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", bus.mem_din_o); end
    checks++; if (bus.done_irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.done_irq_o); end
    bus.addr_i = 4'd0; #1;
    checks++; if (bus.data_o !== 32'h0) begin failures++; $display("FAIL reset_deselected_read got=%h exp=0", bus.data_o); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(4'(i * 4), c);
      checks++; if (c !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", i, c); end
    end
    @(negedge clk);
  endtask
  task automatic test_copy;
    logic [31:0] c;
    int e, r0, w0, q0;
    wr_reg(4'd0, 32'h1E00); wr_reg(4'd4, 32'h1F00); wr_reg(4'd8, 32'd4);
    r0 = acc_rd; w0 = acc_wr; q0 = irq_cnt;
    wr_reg(4'd12, 32'd1);
    e = 1;
    wait_done(e);
    checks++; if (e !== 14) begin failures++; $display("FAIL copy_latency got=%0d exp=14", e); end
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h4) begin failures++; $display("FAIL copy_ctrl got=%h exp=4", c); end
    checks++; if (acc_rd - r0 !== 4 || acc_wr - w0 !== 4) begin failures++; $display("FAIL copy_counts got=%0d/%0d exp=4/4", acc_rd - r0, acc_wr - w0); end
    checks++; if (acc_log !== 8'b1010_1010) begin failures++; $display("FAIL copy_order got=%b exp=10101010", acc_log); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem['h7C0 + i] !== pat(i)) begin failures++; $display("FAIL copy_word%0d got=%h exp=%h", i, mem['h7C0 + i], pat(i)); end
    end
    rd_reg(4'd0, c);
    checks++; if (c !== 32'h1E00) begin failures++; $display("FAIL copy_src_kept got=%h exp=1e00", c); end
    rd_reg(4'd8, c);
    checks++; if (c !== 32'd4) begin failures++; $display("FAIL copy_len_kept got=%h exp=4", c); end
    checks++; if (irq_cnt - q0 !== IRQ_PER) begin failures++; $display("FAIL copy_irq got=%0d exp=%0d", irq_cnt - q0, IRQ_PER); end
    @(negedge clk);
  endtask
  task automatic test_len_zero;
    logic [31:0] c;
    int e, k0;
    wr_reg(4'd8, 32'd0);
    k0 = csb_cycles;
    wr_reg(4'd12, 32'd1);
    e = 1;
    wait_done(e);
    checks++; if (e !== 2) begin failures++; $display("FAIL len0_latency got=%0d exp=2", e); end
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h4) begin failures++; $display("FAIL len0_ctrl got=%h exp=4", c); end
    checks++; if (csb_cycles !== k0) begin failures++; $display("FAIL len0_no_access got=%0d exp=%0d", csb_cycles, k0); end
    @(negedge clk);
  endtask
  task automatic test_misaligned;
    logic [31:0] c;
    int e, k0;
    wr_reg(4'd0, 32'h1E02); wr_reg(4'd8, 32'd4);
    k0 = csb_cycles;
    wr_reg(4'd12, 32'd1);
    e = 1;
    wait_done(e);
    checks++; if (e !== 2) begin failures++; $display("FAIL misal_latency got=%0d exp=2", e); end
    rd_reg(4'd12, c);
    checks++; if (c !== 32'hC) begin failures++; $display("FAIL misal_ctrl got=%h exp=c", c); end
    checks++; if (csb_cycles !== k0) begin failures++; $display("FAIL misal_no_access got=%0d exp=%0d", csb_cycles, k0); end
    @(negedge clk);
    wr_reg(4'd12, 32'hC);
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h0) begin failures++; $display("FAIL misal_w1c got=%h exp=0", c); end
    @(negedge clk);
  endtask
  task automatic test_gnt_stall;
    logic [31:0] c;
    int e, rd_seen, wr_seen, bad;
    wr_reg(4'd0, 32'h1E00); wr_reg(4'd4, 32'h1F80); wr_reg(4'd8, 32'd2);
    bus.mem_gnt_i = 1'b0;
    wr_reg(4'd12, 32'd1);
    e = 1; rd_seen = 0; wr_seen = 0; bad = 0;
    while (e < 200) begin
      if (!bus.mem_csb_o && bus.mem_web_o) begin
        rd_seen++;
        if (rd_seen <= 5 && bus.mem_addr_o !== 11'h780) bad++;
        bus.mem_gnt_i = rd_seen > 5;
      end else if (!bus.mem_csb_o) begin
        wr_seen++;
        if (wr_seen <= 5 && (bus.mem_addr_o !== 11'h7E0 || bus.mem_din_o !== pat(0))) bad++;
        bus.mem_gnt_i = wr_seen > 5;
      end else bus.mem_gnt_i = 1'b1;
      rd_reg(4'd12, c);
      if (c[2]) break;
      @(negedge clk);
      e++;
    end
    bus.mem_gnt_i = 1'b1;
    checks++; if (e !== 18) begin failures++; $display("FAIL stall_latency got=%0d exp=18", e); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", bad); end
    checks++; if (rd_seen !== 7 || wr_seen !== 7) begin failures++; $display("FAIL stall_cycles got=%0d/%0d exp=7/7", rd_seen, wr_seen); end
    checks++; if (mem['h7E0] !== pat(0)) begin failures++; $display("FAIL stall_word0 got=%h exp=%h", mem['h7E0], pat(0)); end
    checks++; if (mem['h7E1] !== pat(1)) begin failures++; $display("FAIL stall_word1 got=%h exp=%h", mem['h7E1], pat(1)); end
    @(negedge clk);
  endtask
  task automatic test_busy_writes;
    logic [31:0] c;
    int e, w0, q0;
    wr_reg(4'd0, 32'h1E00); wr_reg(4'd4, 32'h1FA0); wr_reg(4'd8, 32'd3);
    w0 = acc_wr; q0 = irq_cnt;
    wr_reg(4'd12, 32'd1);
    e = 1;
    wr_reg(4'd8, 32'd9); e++;
    wr_reg(4'd12, 32'd1); e++;
    wr_reg(4'd0, 32'h100); e++;
    rd_reg(4'd8, c);
    checks++; if (c !== 32'd3) begin failures++; $display("FAIL busy_len got=%h exp=3", c); end
    rd_reg(4'd0, c);
    checks++; if (c !== 32'h1E00) begin failures++; $display("FAIL busy_src got=%h exp=1e00", c); end
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h2) begin failures++; $display("FAIL busy_flag got=%h exp=2", c); end
    @(negedge clk); e++;
    wait_done(e);
    checks++; if (e !== 11) begin failures++; $display("FAIL busy_latency got=%0d exp=11", e); end
    repeat (10) @(negedge clk);
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h4) begin failures++; $display("FAIL busy_idle_ctrl got=%h exp=4", c); end
    checks++; if (acc_wr - w0 !== 3) begin failures++; $display("FAIL busy_single_run got=%0d exp=3", acc_wr - w0); end
    checks++; if (irq_cnt - q0 !== IRQ_PER) begin failures++; $display("FAIL busy_irq got=%0d exp=%0d", irq_cnt - q0, IRQ_PER); end
    checks++; if (mem['h7EA] !== pat(2)) begin failures++; $display("FAIL busy_word2 got=%h exp=%h", mem['h7EA], pat(2)); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    logic [31:0] c;
    int k0;
    wr_reg(4'd0, 32'h1E00); wr_reg(4'd4, 32'h1FC0); wr_reg(4'd8, 32'd4);
    wr_reg(4'd12, 32'd1);
    repeat (5) @(negedge clk);
    checks++; if (bus.mem_csb_o !== 1'b0 || bus.mem_web_o !== 1'b0 || bus.mem_addr_o !== 11'h7F1) begin failures++; $display("FAIL rstmid_in_wr got=%b%b/%h exp=00/7f1", bus.mem_csb_o, bus.mem_web_o, bus.mem_addr_o); end
    rst = 1'b1;
    @(negedge clk);
    k0 = csb_cycles;
    checks++; if (bus.mem_csb_o !== 1'b1) begin failures++; $display("FAIL rstmid_csb got=%b exp=1", bus.mem_csb_o); end
    rst = 1'b0;
    rd_reg(4'd12, c);
    checks++; if (c !== 32'h0) begin failures++; $display("FAIL rstmid_ctrl got=%h exp=0", c); end
    for (int i = 0; i < 3; i++) begin
      rd_reg(4'(i * 4), c);
      checks++; if (c !== 32'h0) begin failures++; $display("FAIL rstmid_reg%0d got=%h exp=0", i, c); end
    end
    repeat (5) @(negedge clk);
    checks++; if (csb_cycles !== k0) begin failures++; $display("FAIL rstmid_no_access got=%0d exp=%0d", csb_cycles, k0); end
    checks++; if (mem['h7F2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rstmid_word2 got=%h exp=deadbeef", mem['h7F2]); end
  endtask
  initial begin
    bus.csb_i = 1'b1; bus.wen_i = 1'b1; bus.addr_i = '0; bus.data_i = '0; bus.mem_gnt_i = 1'b1;
    test_reset;
    for (int i = 0; i < 8; i++) load('h780 + i, pat(i));
    for (int i = 0; i < 64; i++) load('h7C0 + i, 32'hDEAD_BEEF);
    test_copy;
    test_len_zero;
    test_misaligned;
    test_gnt_stall;
    test_busy_writes;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
